time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Keypad time-entry controller that configures the timekeeping counter block.
- Sequences six BCD digits (HH MM SS) entered on the 10-key one-hot keypad, validates each digit against clock limits, and buffers the partial entry for display.
- Commits the full time to the counter block through a valid/ready load handshake.
- Sits between the keypad/DIP inputs and the counter datapath; it is the only writer of the counter's preset value.

Parameters:
CLK_HZ, 1000, clk frequency in Hz.
TIMEOUT_S, 10, seconds of keypad inactivity before an entry is aborted.
DEB_CYC, 20, cycles a key must be stable before it is accepted.

Ports:
clk  input  1  system clock, CLK_HZ.
rst  input  1  reset, asynchronous, active-high.
set_mode  input  1  DIP set-mode switch; 1 = request entry.
keypad  input  10  one-hot keys; bit n = digit n.
load_ready  input  1  counter block accepts the preset.
load_valid  output  1  preset available.
load_time  output  24  {h_ten,h_one,m_ten,m_one,s_ten,s_one}, 4-bit BCD each.
edit_digits  output  24  current entry buffer, same packing.
edit_pos  output  3  index of next digit, 0..5.
blink  output  1  cursor blink enable.
err  output  1  one-cycle pulse on a rejected key.

Behaviour:
Reset:
- State IDLE.
- All outputs 0; buffer 0; timers 0; debouncer idle.
- Async assertion drops load_valid immediately.

Key acceptance:
- keypad must return to all-zero, then present exactly one hot bit, stable for DEB_CYC consecutive cycles.
- On acceptance: one-cycle key event carrying code 0..9.
- Multi-hot or unstable inputs restart the stability count.
- Holding a key yields one event only; a repeat needs a release.

State IDLE:
- set_mode rising edge -> ENTRY.
- On entry: buffer cleared, edit_pos=0, inactivity timer cleared.

State ENTRY:
- A key event at edit_pos is checked against its limit:
  - pos0 <= 2
  - pos1 <= 9 if h_ten < 2, else <= 3
  - pos2 <= 5
  - pos3 <= 9
  - pos4 <= 5
  - pos5 <= 9
- Valid key: stored at edit_pos, edit_pos increments, timer clears.
- Invalid key: err=1 for one cycle, buffer and edit_pos unchanged, timer clears.
- Valid key at pos5: stored, then next cycle -> LOAD.
- set_mode low -> IDLE (abort; no load; buffer retained for display).
- Timer reaches TIMEOUT_S*CLK_HZ-1 -> IDLE (abort).
- Key event in the same cycle as timer expiry: key wins, timer clears.
- blink toggles every CLK_HZ/4 cycles in ENTRY; 0 in all other states.

State LOAD:
- load_valid=1; load_time=buffer, held stable while valid.
- Transfer occurs on the cycle where load_valid && load_ready; load_valid=0 the next cycle.
- Commit cannot be aborted: set_mode falling keeps load_valid high until transfer.
- After transfer: -> WAIT_EXIT if set_mode=1, else -> IDLE.
- Keys are ignored.

State WAIT_EXIT:
- Keys ignored.
- set_mode low -> IDLE; a new entry requires a fresh rising edge.

Width rules:
- Timer width = clog2(TIMEOUT_S*CLK_HZ+1).
- BCD digits are never incremented here; no arithmetic wrap.
- edit_pos never exceeds 5.

Optional Feature:
TIME_SET_TIMEOUT_EN
- Defined: inactivity timer and abort-to-IDLE as above.
- Undefined: timer logic removed; ENTRY waits indefinitely; only set_mode low aborts.

Decomposition:
- Package time_set_pkg:
  - state enum (IDLE, ENTRY, LOAD, WAIT_EXIT)
  - BCD digit typedef (4 bits)
  - position constants POS_H_TEN..POS_S_ONE
  - per-position limit constants
  - KEY_NONE constant
- Sub-module key_debounce: keypad + DEB_CYC -> key_evt pulse + key_code[3:0]; instantiated once.

Test Plan:
1. Reset mid-LOAD with load_ready=0 -> load_valid drops the same cycle; state IDLE; edit_pos=0.
2. set_mode 0->1, keys 1,2,3,4,5,6 (each held 30 cycles, released 30), load_ready=1 -> one load_valid pulse with load_time=0x123456; then WAIT_EXIT until set_mode=0.
3. Keys 2 then 5 -> err pulse, edit_pos stays 1; then 3 accepted (h_one=3); then pos2 key 7 -> err; pos2 key 5 accepted.
4. Key 4 held 1000 cycles -> exactly one event; keys 3+4 pressed together -> no event; key held 10 cycles (< DEB_CYC) -> no event.
5. With TIME_SET_TIMEOUT_EN: two digits entered, then idle 10000 cycles -> IDLE, load_valid never asserted; same stimulus without macro -> remains ENTRY.
6. load_ready low 50 cycles while set_mode drops in LOAD -> load_valid and load_time stay constant; transfer on ready; next state IDLE.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// time_set_pkg: shared types and constants for the keypad time-entry controller.
// States, BCD digit type, digit positions and the per-position entry limits.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD,
    WAIT_EXIT
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int NUM_DIGITS = 6;
  localparam int TIME_W     = NUM_DIGITS * 4;

  localparam logic [2:0] POS_H_TEN = 3'd0;
  localparam logic [2:0] POS_H_ONE = 3'd1;
  localparam logic [2:0] POS_M_TEN = 3'd2;
  localparam logic [2:0] POS_M_ONE = 3'd3;
  localparam logic [2:0] POS_S_TEN = 3'd4;
  localparam logic [2:0] POS_S_ONE = 3'd5;

  localparam bcd_t LIM_H_TEN    = 4'd2;
  localparam bcd_t LIM_H_ONE    = 4'd9;
  localparam bcd_t LIM_H_ONE_20 = 4'd3;
  localparam bcd_t LIM_M_TEN    = 4'd5;
  localparam bcd_t LIM_M_ONE    = 4'd9;
  localparam bcd_t LIM_S_TEN    = 4'd5;
  localparam bcd_t LIM_S_ONE    = 4'd9;

  localparam bcd_t KEY_NONE = 4'hF;

  // Largest digit accepted at a position; the hour-ones limit depends on the
  // hour-tens digit already entered so that 20..23 is the top of the range.
  function automatic bcd_t digit_limit(input logic [2:0] pos, input bcd_t h_ten);
    bcd_t lim;
    lim = 4'd0;
    case (pos)
      POS_H_TEN: lim = LIM_H_TEN;
      POS_H_ONE: lim = (h_ten < 4'd2) ? LIM_H_ONE : LIM_H_ONE_20;
      POS_M_TEN: lim = LIM_M_TEN;
      POS_M_ONE: lim = LIM_M_ONE;
      POS_S_TEN: lim = LIM_S_TEN;
      POS_S_ONE: lim = LIM_S_ONE;
      default:   lim = 4'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: preset load handshake towards the timekeeping counter.
// The controller is the master (drives valid and the BCD time), the counter
// block is the slave (drives ready).
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [TIME_W-1:0] load_time;

  modport master (output load_valid, output load_time, input load_ready);
  modport slave  (input load_valid, input load_time, output load_ready);

endinterface

// File: rtl/time_set_ctrl_key_debounce.sv
// key_debounce: synchronises the 10-key one-hot keypad and emits a single
// one-cycle event with the digit code once a lone key has been stable for
// DEB_CYC cycles after the keypad was seen fully released.
module key_debounce
  import time_set_pkg::*;
#(
  parameter int DEB_CYC = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       key_evt,
  output bcd_t       key_code
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYC);

  logic [9:0]       kp_meta;
  logic [9:0]       kp_sync;
  logic [9:0]       kp_last;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             armed;
  logic             fire;
  logic             is_onehot;

  function automatic bcd_t encode_key(input logic [9:0] k);
    bcd_t code;
    code = KEY_NONE;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) code = bcd_t'(i);
    end
    return code;
  endfunction

  // Two-flop synchroniser: the keypad is a mechanical, asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_meta <= '0;
      kp_sync <= '0;
    end else begin
      kp_meta <= keypad;
      kp_sync <= kp_meta;
    end
  end

  // Stability run length of the current single key; saturates so a held key cannot refire.
  always_comb begin
    cnt_next  = '0;
    is_onehot = $onehot(kp_sync);
    if (is_onehot) begin
      if (kp_sync == kp_last) begin
        cnt_next = (stable_cnt == CNT_DONE) ? stable_cnt : stable_cnt + CNT_W'(1);
      end else begin
        cnt_next = CNT_W'(1);
      end
    end
    fire = armed && is_onehot && (cnt_next == CNT_DONE);
  end

  // Event generation; a fired key disarms until the keypad reads all-zero again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_last    <= '0;
      stable_cnt <= '0;
      armed      <= 1'b0;
      key_evt    <= 1'b0;
      key_code   <= KEY_NONE;
    end else begin
      kp_last    <= kp_sync;
      stable_cnt <= cnt_next;
      key_evt    <= fire;
      key_code   <= fire ? encode_key(kp_sync) : KEY_NONE;
      if (kp_sync == '0) begin
        armed <= 1'b1;
      end else if (fire) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad time-entry controller for the timekeeping counter.
// Collects HH MM SS as six validated BCD digits, then commits them through
// the load valid/ready handshake.
// Optional feature macro: TIME_SET_TIMEOUT_EN enables the keypad-inactivity
// abort; without it an entry waits until set_mode is released.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int TIMEOUT_S = 10,
  parameter int DEB_CYC   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_mode,
  input  logic [9:0]        keypad,
  time_set_ctrl_if.master   load,
  output logic [TIME_W-1:0] edit_digits,
  output logic [2:0]        edit_pos,
  output logic              blink,
  output logic              err
);

  localparam int BLINK_CYC = CLK_HZ / 4;
  localparam int BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  state_t            state;
  bcd_t              digits [NUM_DIGITS];
  logic [BLINK_W-1:0] blink_cnt;
  logic              mode_meta;
  logic              mode_sync;
  logic              mode_prev;
  logic              mode_rise;
  logic              key_evt;
  bcd_t              key_code;
  logic              key_ok;
  logic              timeout_hit;
  logic [TIME_W-1:0] final_time;

  key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_key_debounce (
    .clk      (clk),
    .rst      (rst),
    .keypad   (keypad),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  // Synchronise the DIP switch and keep its previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
      mode_prev <= 1'b0;
    end else begin
      mode_meta <= set_mode;
      mode_sync <= mode_meta;
      mode_prev <= mode_sync;
    end
  end

  assign mode_rise   = mode_sync && !mode_prev;
  assign key_ok      = (key_code <= digit_limit(edit_pos, digits[0]));
  assign final_time  = {digits[0], digits[1], digits[2], digits[3], digits[4], key_code};
  assign edit_digits = {digits[0], digits[1], digits[2], digits[3], digits[4], digits[5]};

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer;

  assign timeout_hit = (timer == TMR_LAST);

  // Inactivity timer: runs only in ENTRY, any key event (accepted or rejected) restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state != ENTRY || key_evt) begin
      timer <= '0;
    end else if (!timeout_hit) begin
      timer <= timer + TMR_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Entry sequencer with registered outputs: digit buffer, cursor, blink, error and load handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      digits          <= '{default: '0};
      edit_pos        <= 3'd0;
      blink           <= 1'b0;
      blink_cnt       <= '0;
      err             <= 1'b0;
      load.load_valid <= 1'b0;
      load.load_time  <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mode_rise) begin
            state     <= ENTRY;
            digits    <= '{default: '0};
            edit_pos  <= 3'd0;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end
        end

        ENTRY: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
          end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
          end

          if (!mode_sync) begin
            state     <= IDLE;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (key_evt) begin
            if (key_ok) begin
              digits[edit_pos] <= key_code;
              if (edit_pos == POS_S_ONE) begin
                state           <= LOAD;
                load.load_valid <= 1'b1;
                load.load_time  <= final_time;
                blink           <= 1'b0;
                blink_cnt       <= '0;
              end else begin
                edit_pos <= edit_pos + 3'd1;
              end
            end else begin
              err <= 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end
        end

        LOAD: begin
          if (load.load_valid && load.load_ready) begin
            load.load_valid <= 1'b0;
            state           <= mode_sync ? WAIT_EXIT : IDLE;
          end
        end

        WAIT_EXIT: begin
          if (!mode_sync) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: self-checking bench for time_set_ctrl. A behavioural
// model of the entry rules is compared against every output each cycle,
// plus directed literal checks. Build with TIME_SET_TIMEOUT_EN to cover
// the inactivity abort.
module tb_time_set_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int TIMEOUT_S   = 10;
  localparam int DEB_CYC     = 20;
  localparam int BLINK_CYC   = CLK_HZ / 4;
`ifdef TIME_SET_TIMEOUT_EN
  localparam int TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_mode = 1'b0;
  logic [9:0]  keypad = '0;
  logic [23:0] edit_digits;
  logic [2:0]  edit_pos;
  logic        blink;
  logic        err;

  time_set_ctrl_if load_bus ();

  time_set_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_S (TIMEOUT_S),
    .DEB_CYC   (DEB_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_mode    (set_mode),
    .keypad      (keypad),
    .load        (load_bus),
    .edit_digits (edit_digits),
    .edit_pos    (edit_pos),
    .blink       (blink),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observation counters kept by the compare process
  int          xfers = 0;
  int          valid_cycles = 0;
  int          err_pulses = 0;
  bit          blink_seen = 1'b0;
  logic [23:0] last_xfer = '0;

  // behavioural model state
  logic [9:0]  mk1, mk2, m_last;
  int          m_run;
  bit          m_released, m_evt;
  int          m_code;
  bit          ms1, ms2, ms_prev;
  int          m_phase;          // 0 idle, 1 entering, 2 committing, 3 waiting for switch off
  int          m_buf [6];
  int          m_pos;
  bit          m_blink;
  int          m_bcnt;
  bit          m_err;
  bit          m_lv;
  logic [23:0] m_lt;
`ifdef TIME_SET_TIMEOUT_EN
  int          m_timer;
`endif

  task automatic print_summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      if (errors >= 50) begin
        print_summary();
        $finish;
      end
    end
  endtask

  // A digit is acceptable if the partial time can still be a legal 24h clock reading.
  function automatic bit digit_ok(input int pos, input int code, input int h_ten);
    case (pos)
      0:       return code <= 2;
      1:       return (h_ten * 10 + code) <= 23;
      2, 4:    return code <= 5;
      default: return code <= 9;
    endcase
  endfunction

  function automatic logic [23:0] model_pack();
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) p[23 - 4*i -: 4] = m_buf[i][3:0];
    return p;
  endfunction

  task automatic model_reset();
    mk1 = '0; mk2 = '0; m_last = '0; m_run = 0; m_released = 1'b0; m_evt = 1'b0; m_code = 0;
    ms1 = 1'b0; ms2 = 1'b0; ms_prev = 1'b0;
    m_phase = 0; m_pos = 0; m_blink = 1'b0; m_bcnt = 0; m_err = 1'b0; m_lv = 1'b0; m_lt = '0;
    for (int i = 0; i < 6; i++) m_buf[i] = 0;
`ifdef TIME_SET_TIMEOUT_EN
    m_timer = 0;
`endif
  endtask

  // One clock of the model: entry rules act on last cycle's key event and
  // switch level, then the key filter and input synchronisers advance.
  task automatic model_step();
    m_err = 1'b0;
    case (m_phase)
      0: begin
        if (ms2 && !ms_prev) begin
          m_phase = 1;
          for (int i = 0; i < 6; i++) m_buf[i] = 0;
          m_pos = 0; m_blink = 1'b0; m_bcnt = 0;
`ifdef TIME_SET_TIMEOUT_EN
          m_timer = 0;
`endif
        end
      end
      1: begin
        m_bcnt++;
        if (m_bcnt == BLINK_CYC) begin
          m_bcnt = 0;
          m_blink = ~m_blink;
        end
        if (!ms2) begin
          m_phase = 0; m_blink = 1'b0; m_bcnt = 0;
        end else if (m_evt) begin
`ifdef TIME_SET_TIMEOUT_EN
          m_timer = 0;
`endif
          if (digit_ok(m_pos, m_code, m_buf[0])) begin
            m_buf[m_pos] = m_code;
            if (m_pos == 5) begin
              m_phase = 2; m_lv = 1'b1; m_lt = model_pack(); m_blink = 1'b0; m_bcnt = 0;
            end else begin
              m_pos++;
            end
          end else begin
            m_err = 1'b1;
          end
        end else begin
`ifdef TIME_SET_TIMEOUT_EN
          if (m_timer == TIMEOUT_CYC - 1) begin
            m_phase = 0; m_blink = 1'b0; m_bcnt = 0;
          end else begin
            m_timer++;
          end
`endif
        end
      end
      2: begin
        if (m_lv && load_bus.load_ready) begin
          m_lv = 1'b0;
          m_phase = ms2 ? 3 : 0;
        end
      end
      default: begin
        if (!ms2) m_phase = 0;
      end
    endcase

    m_evt = 1'b0;
    if (mk2 == '0) begin
      m_released = 1'b1;
      m_run = 0;
    end else if ($onehot(mk2)) begin
      m_run = (mk2 == m_last) ? m_run + 1 : 1;
      if (m_released && m_run == DEB_CYC) begin
        m_evt = 1'b1;
        m_released = 1'b0;
        for (int i = 0; i < 10; i++) if (mk2[i]) m_code = i;
      end
    end else begin
      m_run = 0;
    end
    m_last = mk2;

    mk2 = mk1; mk1 = keypad;
    ms_prev = ms2; ms2 = ms1; ms1 = set_mode;
  endtask

  // Model process: follows the asynchronous reset and every rising clock edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare process: checks all outputs against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_output("load_valid",  {23'b0, load_bus.load_valid}, {23'b0, m_lv});
        check_output("load_time",   load_bus.load_time, m_lt);
        check_output("edit_digits", edit_digits, model_pack());
        check_output("edit_pos",    24'(edit_pos), 24'(m_pos));
        check_output("blink",       {23'b0, blink}, {23'b0, m_blink});
        check_output("err",         {23'b0, err}, {23'b0, m_err});
        if (load_bus.load_valid) valid_cycles++;
        if (load_bus.load_valid && load_bus.load_ready) begin
          xfers++;
          last_xfer = load_bus.load_time;
        end
        if (err) err_pulses++;
        if (blink) blink_seen = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    print_summary();
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_stimulus(input logic [9:0] pattern, input int hold, input int rel);
    keypad = pattern;
    ticks(hold);
    keypad = '0;
    ticks(rel);
  endtask

  task automatic press_digit(input int d);
    apply_stimulus(10'b1 << d, 30, 30);
  endtask

  task automatic enter_time(input int d0, input int d1, input int d2,
                            input int d3, input int d4, input int d5);
    press_digit(d0); press_digit(d1); press_digit(d2);
    press_digit(d3); press_digit(d4); press_digit(d5);
  endtask

  int base_err, base_xfer, base_valid, held;
  int r, k, d, hold, rel;
  logic [9:0] pat;

  initial begin
    load_bus.load_ready = 1'b1;
    ticks(5);
    check_output("rst_load_valid", {23'b0, load_bus.load_valid}, 24'h0);
    check_output("rst_edit_pos",   24'(edit_pos), 24'h0);
    check_output("rst_edit_digits", edit_digits, 24'h0);
    check_output("rst_blink",      {23'b0, blink}, 24'h0);
    check_output("rst_err",        {23'b0, err}, 24'h0);
    rst = 1'b0;
    ticks(5);

    // full entry 12:34:56 with ready high
    base_xfer = xfers; base_valid = valid_cycles;
    set_mode = 1'b1; ticks(10);
    enter_time(1, 2, 3, 4, 5, 6);
    check_output("t2_xfers", 24'(xfers - base_xfer), 24'd1);
    check_output("t2_time", last_xfer, 24'h123456);
    check_output("t2_valid_cycles", 24'(valid_cycles - base_valid), 24'd1);
    press_digit(7);
    check_output("t2_wait_digits", edit_digits, 24'h123456);
    check_output("t2_wait_pos", 24'(edit_pos), 24'd5);
    set_mode = 1'b0; ticks(10);

    // digit limit checks
    set_mode = 1'b1; ticks(10);
    base_err = err_pulses;
    press_digit(2); press_digit(5);
    check_output("t3_err_h_one", 24'(err_pulses - base_err), 24'd1);
    check_output("t3_pos_stay", 24'(edit_pos), 24'd1);
    press_digit(3);
    check_output("t3_h_one", {20'b0, edit_digits[19:16]}, 24'h3);
    press_digit(7);
    check_output("t3_err_m_ten", 24'(err_pulses - base_err), 24'd2);
    press_digit(5);
    check_output("t3_pos_m_ten", 24'(edit_pos), 24'd3);
    set_mode = 1'b0; ticks(10);
    check_output("t3_abort_digits", edit_digits, 24'h235000);

    // debounce behaviour
    set_mode = 1'b1; ticks(10);
    base_err = err_pulses;
    apply_stimulus(10'b1 << 4, 1000, 30);
    check_output("t4_long_hold", 24'(err_pulses - base_err), 24'd1);
    apply_stimulus(10'b0000011000, 100, 30);
    check_output("t4_multi_hot", 24'(err_pulses - base_err), 24'd1);
    apply_stimulus(10'b1 << 1, 10, 30);
    check_output("t4_short_press", 24'(edit_pos), 24'd0);
    apply_stimulus(10'b1 << 1, 30, 30);
    check_output("t4_good_press", 24'(edit_pos), 24'd1);
    set_mode = 1'b0; ticks(10);

    // inactivity
    base_valid = valid_cycles;
    set_mode = 1'b1; ticks(10);
    press_digit(1); press_digit(2);
    ticks(10100);
    blink_seen = 1'b0;
    ticks(600);
    press_digit(3);
`ifdef TIME_SET_TIMEOUT_EN
    check_output("t5_blink_idle", {23'b0, blink_seen}, 24'd0);
    check_output("t5_pos_after_abort", 24'(edit_pos), 24'd2);
`else
    check_output("t5_blink_entry", {23'b0, blink_seen}, 24'd1);
    check_output("t5_pos_still_entry", 24'(edit_pos), 24'd3);
`endif
    check_output("t5_no_load", 24'(valid_cycles - base_valid), 24'd0);
    set_mode = 1'b0; ticks(10);

    // commit held while ready low and switch dropped
    load_bus.load_ready = 1'b0;
    set_mode = 1'b1; ticks(10);
    enter_time(0, 9, 5, 9, 5, 9);
    check_output("t6_valid", {23'b0, load_bus.load_valid}, 24'd1);
    check_output("t6_time", load_bus.load_time, 24'h095959);
    set_mode = 1'b0;
    base_xfer = xfers;
    held = 0;
    repeat (50) begin
      tick();
      if (load_bus.load_valid === 1'b1 && load_bus.load_time === 24'h095959) held++;
    end
    check_output("t6_held", 24'(held), 24'd50);
    load_bus.load_ready = 1'b1;
    tick();
    check_output("t6_drop", {23'b0, load_bus.load_valid}, 24'd0);
    check_output("t6_xfer", 24'(xfers - base_xfer), 24'd1);
    press_digit(1);
    ticks(10);

    // asynchronous reset during a pending commit
    load_bus.load_ready = 1'b0;
    set_mode = 1'b1; ticks(10);
    enter_time(2, 3, 5, 9, 5, 9);
    check_output("t1_pre_valid", {23'b0, load_bus.load_valid}, 24'd1);
    ticks(3);
    rst = 1'b1;
    #1;
    check_output("t1_valid_drop", {23'b0, load_bus.load_valid}, 24'd0);
    check_output("t1_pos", 24'(edit_pos), 24'd0);
    check_output("t1_digits", edit_digits, 24'h0);
    set_mode = 1'b0;
    ticks(3);
    rst = 1'b0;
    load_bus.load_ready = 1'b1;
    ticks(5);

    // randomized entries, keys, switch flips and ready
    repeat (200) begin
      r = $urandom_range(0, 99);
      if (r < 12) set_mode = ~set_mode;
      load_bus.load_ready = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 99);
      if (k < 70) begin
        d = $urandom_range(0, 5);
        pat = 10'b1 << d;
      end else if (k < 90) begin
        d = $urandom_range(0, 9);
        pat = 10'b1 << d;
      end else begin
        d = $urandom_range(0, 9);
        pat = 10'b1 << d;
        d = $urandom_range(0, 9);
        pat = pat | (10'b1 << d);
      end
      hold = $urandom_range(5, 40);
      rel  = $urandom_range(0, 25);
      apply_stimulus(pat, hold, rel);
    end

    set_mode = 1'b0;
    load_bus.load_ready = 1'b1;
    ticks(100);
    print_summary();
    $finish;
  end

endmodule
